// File: rtl/riscv_lsu_pkg.sv
// ============================================================================
//  Module      : riscv_lsu_pkg
//  Description : Shared definitions for the on-chip load/store unit: access
//                size encodings, byte-lane masks and the controller state
//                encoding. Optional feature macro: RISCV_LSU_SPLIT_EN adds
//                the two states used for misaligned (split) accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_lsu_pkg;

  // req_size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Byte lanes of an access at offset 0; shifted left by the byte offset
  localparam logic [3:0] LANES_BYTE = 4'b0001;
  localparam logic [3:0] LANES_HALF = 4'b0011;
  localparam logic [3:0] LANES_WORD = 4'b1111;

`ifdef RISCV_LSU_SPLIT_EN
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_WAIT    = 3'd1,
    ST_RESP       = 3'd2,
    ST_SPLIT2     = 3'd3,
    ST_SPLIT_WAIT = 3'd4
  } lsu_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } lsu_state_e;
`endif

  // Unshifted lane mask for a size; the illegal size selects no lanes
  function automatic logic [3:0] size_lanes(input logic [1:0] size);
    logic [3:0] lanes;
    case (size)
      SIZE_BYTE: lanes = LANES_BYTE;
      SIZE_HALF: lanes = LANES_HALF;
      SIZE_WORD: lanes = LANES_WORD;
      default:   lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_lsu_align.sv
// ============================================================================
//  Module      : riscv_lsu_align
//  Description : Purely combinational lane alignment for the LSU.
//                Store side: byte enables and lane-positioned write data.
//                Load side : selected lanes shifted to bit 0, then sign- or
//                zero-extended. Optional feature macro: RISCV_LSU_SPLIT_EN
//                adds the second-word (upper spill) lanes and read data.
//  Ports       : size_i/off_i/unsigned_i - access shape
//                wdata_i                 - right-justified store data
//                rdata_lo_i[/rdata_hi_i] - first [and second] read word
//                be_lo_o[/be_hi_o]       - byte enables, first [second] word
//                wdata_lo_o[/wdata_hi_o] - write data, first [second] word
//                rdata_o                 - extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
`ifdef RISCV_LSU_SPLIT_EN
  input  logic [31:0] rdata_hi_i,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wdata_hi_o,
`endif
  output logic [3:0]  be_lo_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  mask8;
  logic [4:0]  sh;
  logic [31:0] rep;
  logic [31:0] raw;
`ifdef RISCV_LSU_SPLIT_EN
  logic [5:0]  sh_inv;
`endif

  always_comb begin
    sh    = {off_i, 3'b000};
    // An 8-bit mask lets lanes run past byte 3 into the following word
    mask8 = {4'b0000, size_lanes(size_i)} << off_i;
    be_lo_o = mask8[3:0];

    case (size_i)
      SIZE_BYTE: rep = {4{wdata_i[7:0]}};
      SIZE_HALF: rep = {2{wdata_i[15:0]}};
      default:   rep = wdata_i;
    endcase
    wdata_lo_o = rep << sh;

`ifdef RISCV_LSU_SPLIT_EN
    be_hi_o = mask8[7:4];
    // Bytes pushed out of the first word land at the bottom of the second;
    // a shift of 32 (offset 0) yields zero
    sh_inv     = 6'd32 - {1'b0, sh};
    wdata_hi_o = rep >> sh_inv;
    raw        = (rdata_lo_i >> sh) | (rdata_hi_i << sh_inv);
`else
    raw        = rdata_lo_i >> sh;
`endif

    case (size_i)
      SIZE_BYTE: rdata_o = unsigned_i ? {24'h0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SIZE_HALF: rdata_o = unsigned_i ? {16'h0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      default:   rdata_o = raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_lsu_onchip.sv
// ============================================================================
//  Module      : riscv_lsu_onchip
//  Description : Load/store unit for a single-cycle-latency on-chip memory.
//                One access outstanding; valid/ready request, one-cycle
//                response pulse. Optional feature macro: RISCV_LSU_SPLIT_EN
//                (misaligned accesses split into two word accesses; without
//                it, misaligned accesses return an error).
//  Ports       : clk, reset (async, active high)
//                req_*  - request channel (valid/ready, write, size,
//                         unsigned, addr, wdata)
//                rsp_*  - response pulse, error flag, load data
//                mem_*  - memory port, read data one cycle after issue
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_lsu_onchip
  import riscv_lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_error,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [31:0]           mem_writedata,
  input  logic [31:0]           mem_readdata
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  unsigned_q, unsigned_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic [31:0]           offs;
  logic [ADDR_WIDTH-1:0] req_word;
  logic                  in_window;
  logic                  req_err;

  logic [1:0]            al_size;
  logic [1:0]            al_off;
  logic [3:0]            al_be_lo;
  logic [31:0]           al_wdata_lo;
  logic [31:0]           al_rdata_lo;
  logic [31:0]           al_rdata;

`ifdef RISCV_LSU_SPLIT_EN
  localparam logic [ADDR_WIDTH-1:0] WORD_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  logic                  split_q, split_d;
  logic [3:0]            be_hi_q, be_hi_d;
  logic [31:0]           wdata_hi_q, wdata_hi_d;
  logic [31:0]           lo_data_q, lo_data_d;
  logic [3:0]            al_be_hi;
  logic [31:0]           al_wdata_hi;
  logic [31:0]           al_rdata_hi;
  logic                  split_req;
`else
  logic                  misaligned;
`endif

  // BASE_ADDR is window-aligned, so the low offset bits equal req_addr's
  assign offs      = req_addr - BASE_ADDR;
  assign req_word  = offs[ADDR_WIDTH+1:2];
  assign in_window = (offs[31:ADDR_WIDTH+2] == '0);

  // Request fields drive alignment while idle; captured fields afterwards
  assign al_size = (state_q == ST_IDLE) ? req_size   : size_q;
  assign al_off  = (state_q == ST_IDLE) ? offs[1:0]  : off_q;

`ifdef RISCV_LSU_SPLIT_EN
  assign al_rdata_lo = (state_q == ST_SPLIT_WAIT) ? lo_data_q    : mem_readdata;
  assign al_rdata_hi = (state_q == ST_SPLIT_WAIT) ? mem_readdata : 32'h0;
  assign split_req   = |al_be_hi;
  // A split whose first word is the last in the window would spill past it
  assign req_err     = (req_size == SIZE_ILL) || !in_window ||
                       (split_req && (req_word == '1));
`else
  assign al_rdata_lo = mem_readdata;
  assign misaligned  = ((req_size == SIZE_HALF) && offs[0]) ||
                       ((req_size == SIZE_WORD) && (offs[1:0] != 2'b00));
  assign req_err     = (req_size == SIZE_ILL) || !in_window || misaligned;
`endif

  riscv_lsu_align u_align (
    .size_i     (al_size),
    .off_i      (al_off),
    .unsigned_i (unsigned_q),
    .wdata_i    (req_wdata),
    .rdata_lo_i (al_rdata_lo),
`ifdef RISCV_LSU_SPLIT_EN
    .rdata_hi_i (al_rdata_hi),
    .be_hi_o    (al_be_hi),
    .wdata_hi_o (al_wdata_hi),
`endif
    .be_lo_o    (al_be_lo),
    .wdata_lo_o (al_wdata_lo),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    size_d         = size_q;
    off_d          = off_q;
    unsigned_d     = unsigned_q;
    rsp_valid_d    = 1'b0;
    rsp_error_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
`ifdef RISCV_LSU_SPLIT_EN
    split_d        = split_q;
    be_hi_d        = be_hi_q;
    wdata_hi_d     = wdata_hi_q;
    lo_data_d      = lo_data_q;
`endif
    // Gating with reset keeps the memory port quiet while reset is held
    req_ready      = (state_q == ST_IDLE) && !reset;
    mem_chipselect = 1'b0;
    mem_address    = word_q;
    mem_byteenable = al_be_lo;
    mem_write      = 1'b0;
    mem_writedata  = al_wdata_lo;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !reset) begin
          word_d     = req_word;
          size_d     = req_size;
          off_d      = offs[1:0];
          unsigned_d = req_unsigned;
`ifdef RISCV_LSU_SPLIT_EN
          split_d    = split_req;
          be_hi_d    = al_be_hi;
          wdata_hi_d = al_wdata_hi;
`endif
          if (req_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            mem_chipselect = 1'b1;
            mem_address    = req_word;
            mem_write      = req_write;
            if (req_write) begin
`ifdef RISCV_LSU_SPLIT_EN
              state_d     = split_req ? ST_SPLIT2 : ST_RESP;
              rsp_valid_d = !split_req;
`else
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
`endif
            end else begin
              state_d = ST_RD_WAIT;
            end
          end
        end
      end
      ST_RD_WAIT: begin
`ifdef RISCV_LSU_SPLIT_EN
        if (split_q) begin
          // Hold the first word while the second one is fetched
          lo_data_d      = mem_readdata;
          mem_chipselect = 1'b1;
          mem_address    = word_q + WORD_ONE;
          mem_byteenable = be_hi_q;
          state_d        = ST_SPLIT_WAIT;
        end else
`endif
        begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = al_rdata;
        end
      end
`ifdef RISCV_LSU_SPLIT_EN
      ST_SPLIT2: begin
        mem_chipselect = 1'b1;
        mem_address    = word_q + WORD_ONE;
        mem_byteenable = be_hi_q;
        mem_write      = 1'b1;
        mem_writedata  = wdata_hi_q;
        state_d        = ST_RESP;
        rsp_valid_d    = 1'b1;
      end
      ST_SPLIT_WAIT: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = al_rdata;
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      size_q      <= SIZE_BYTE;
      off_q       <= 2'b00;
      unsigned_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef RISCV_LSU_SPLIT_EN
      split_q     <= 1'b0;
      be_hi_q     <= 4'b0000;
      wdata_hi_q  <= 32'h0;
      lo_data_q   <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      size_q      <= size_d;
      off_q       <= off_d;
      unsigned_q  <= unsigned_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef RISCV_LSU_SPLIT_EN
      split_q     <= split_d;
      be_hi_q     <= be_hi_d;
      wdata_hi_q  <= wdata_hi_d;
      lo_data_q   <= lo_data_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu_onchip.sv
// ============================================================================
//  Module      : tb_riscv_lsu_onchip
//  Description : Self-checking bench for riscv_lsu_onchip with a behavioural
//                word memory and a response scoreboard. Expectations follow
//                the RISCV_LSU_SPLIT_EN macro when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_riscv_lsu_onchip;
  import riscv_lsu_pkg::*;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_error;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write;
  logic [31:0]   mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  riscv_lsu_onchip #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_error      (rsp_error),
    .rsp_rdata      (rsp_rdata),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata)
  );

  // Behavioural memory: registered address, data one cycle after issue
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        rd_q <= mem[mem_address];
      end
    end
  end
  assign mem_readdata = rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts memory accesses, pops the scoreboard on each response
  int            cs_count = 0;
  logic [AW-1:0] cs_addr_q[$];
  logic [3:0]    cs_be_q[$];
  always @(negedge clk) begin
    if (mem_chipselect) begin
      cs_count++;
      cs_addr_q.push_back(mem_address);
      cs_be_q.push_back(mem_byteenable);
    end
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("rsp_cycle", cyc, mon_e.cyc);
        check_val("rsp_error", {31'h0, rsp_error}, {31'h0, mon_e.err});
        check_val("rsp_rdata", rsp_rdata, mon_e.rdata);
      end
    end
  end

  // Snapshot of the memory port in the accepting cycle
  logic          snap_cs, snap_we;
  logic [AW-1:0] snap_addr;
  logic [3:0]    snap_be;
  logic [31:0]   snap_wd;
  logic [31:0]   last_rdata = 32'h0;

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic push,
                       input logic err, input logic [31:0] exp_rd, input int lat);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check_val("req_ready_timeout", {31'h0, req_ready}, 32'h1);
    end else begin
      snap_cs = mem_chipselect; snap_we = mem_write; snap_addr = mem_address;
      snap_be = mem_byteenable; snap_wd = mem_writedata;
      if (push) sb_q.push_back('{err: err, rdata: exp_rd, cyc: cyc + lat});
    end
    @(posedge clk); #1;
    // Scramble the idle request fields: the DUT must use its captured copy
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      check_val("drain_timeout", sb_q.size(), 32'h0);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic err, input logic [31:0] rd_exp, input int lat, input int n_cs);
    int cs0;
    logic [31:0] e_rd;
    cs0 = cs_count;
    cs_addr_q.delete(); cs_be_q.delete();
    e_rd = err ? 32'h0 : (wr ? last_rdata : rd_exp);
    issue(wr, sz, uns, addr, wd, 1'b1, err, e_rd, lat);
    drain();
    check_val("cs_count", cs_count - cs0, n_cs);
    last_rdata = e_rd;
  endtask

  int cs_base;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_WORD;
    req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
    for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'h0;
    mem[16'h10]   <= 32'h8899AABB;
    mem[16'h11]   <= 32'h44332211;
    mem[16'h1FFF] <= 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_val("reset_rsp_error", {31'h0, rsp_error}, 32'h0);
    check_val("reset_rsp_rdata", rsp_rdata, 32'h0);
    check_val("reset_cs",        {31'h0, mem_chipselect}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_val("ready_after_reset", {31'h0, req_ready}, 32'h1);

    // Aligned loads of several sizes and extensions
    run(1'b0, SIZE_BYTE, 1'b0, 32'h41, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 1);
    run(1'b0, SIZE_BYTE, 1'b1, 32'h43, 32'h0, 1'b0, 32'h00000088, 2, 1);
    run(1'b0, SIZE_HALF, 1'b0, 32'h42, 32'h0, 1'b0, 32'hFFFF8899, 2, 1);
    run(1'b0, SIZE_HALF, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0000AABB, 2, 1);
    run(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h8899AABB, 2, 1);

    // Misaligned accesses
`ifdef RISCV_LSU_SPLIT_EN
    run(1'b0, SIZE_WORD, 1'b0, 32'h43, 32'h0, 1'b0, 32'h33221188, 3, 2);
    check_val("split_addr0", cs_addr_q[0], 32'h10);
    check_val("split_be0",   cs_be_q[0],   32'h8);
    check_val("split_addr1", cs_addr_q[1], 32'h11);
    check_val("split_be1",   cs_be_q[1],   32'h7);
    run(1'b0, SIZE_HALF, 1'b0, 32'h41, 32'h0, 1'b0, 32'hFFFF99AA, 2, 1);
    run(1'b0, SIZE_HALF, 1'b1, 32'h43, 32'h0, 1'b0, 32'h00001188, 3, 2);
`else
    run(1'b0, SIZE_WORD, 1'b0, 32'h43, 32'h0, 1'b1, 32'h0, 1, 0);
    run(1'b0, SIZE_HALF, 1'b0, 32'h41, 32'h0, 1'b1, 32'h0, 1, 0);
    run(1'b0, SIZE_HALF, 1'b1, 32'h43, 32'h0, 1'b1, 32'h0, 1, 0);
`endif

    // Half store into the upper lanes, then read back the merged word
    run(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h8899AABB, 2, 1);
    run(1'b1, SIZE_HALF, 1'b0, 32'h42, 32'h00001234, 1'b0, 32'h0, 1, 1);
    check_val("sh_cs",    {31'h0, snap_cs}, 32'h1);
    check_val("sh_we",    {31'h0, snap_we}, 32'h1);
    check_val("sh_addr",  snap_addr, 32'h10);
    check_val("sh_be",    snap_be,   32'hC);
    check_val("sh_wdata", snap_wd,   32'h12340000);
    run(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h1234AABB, 2, 1);

    // Byte store with junk in the upper bits of the store data
    run(1'b1, SIZE_BYTE, 1'b0, 32'h81, 32'hFFFFFFA5, 1'b0, 32'h0, 1, 1);
    check_val("sb_be", snap_be, 32'h2);
    run(1'b0, SIZE_BYTE, 1'b0, 32'h81, 32'h0, 1'b0, 32'hFFFFFFA5, 2, 1);
`ifdef RISCV_LSU_SPLIT_EN
    run(1'b1, SIZE_WORD, 1'b0, 32'h82, 32'hDEADBEEF, 1'b0, 32'h0, 2, 2);
    run(1'b0, SIZE_WORD, 1'b0, 32'h80, 32'h0, 1'b0, 32'hBEEFA500, 2, 1);
    run(1'b0, SIZE_WORD, 1'b0, 32'h84, 32'h0, 1'b0, 32'h0000DEAD, 2, 1);
`else
    run(1'b1, SIZE_WORD, 1'b0, 32'h82, 32'hDEADBEEF, 1'b1, 32'h0, 1, 0);
    run(1'b0, SIZE_WORD, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0000A500, 2, 1);
`endif

    // Window boundaries and illegal size
    run(1'b0, SIZE_WORD, 1'b0, 32'h7FFC, 32'h0, 1'b0, 32'hCAFEF00D, 2, 1);
    run(1'b0, SIZE_WORD, 1'b0, 32'h7FFD, 32'h0, 1'b1, 32'h0, 1, 0);
    run(1'b0, SIZE_WORD, 1'b0, 32'h8000, 32'h0, 1'b1, 32'h0, 1, 0);
    run(1'b0, SIZE_ILL,  1'b0, 32'h40,   32'h0, 1'b1, 32'h0, 1, 0);

    // Reset while a load waits for memory data
    cs_base = cs_count;
    issue(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    reset = 1'b1;
    #1;
    check_val("abort_cs",        {31'h0, mem_chipselect}, 32'h0);
    check_val("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    check_val("abort_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_val("ready_after_abort", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    check_val("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
    check_val("abort_cs_count", cs_count - cs_base, 32'h1);
    last_rdata = 32'h0;
    run(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h1234AABB, 2, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
